axi4_stream_byte_trim: RTL and testbench

// - Removes a per-packet number of leading bytes from an AXI4-Stream packet and repacks the rest.
// - Output words are full; only the last word is partial, with low-aligned tkeep.
// - Sits downstream of axi4_stream_byte_shift: strips the null/header bytes that stage inserted.
// - Restores contiguous LSB-first packing for downstream width converters and FIFOs.

---
 rtl/axi4_lib_pkg.sv | 30 +++
 rtl/axi4_stream_if.sv | 20 ++
 rtl/axi4_stream_byte_merge.sv | 59 +++++
 rtl/axi4_stream_byte_trim.sv | 158 +++++++++++++++
 tb/tb_axi4_stream_byte_trim.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lib_pkg.sv
// Shared AXI4-Stream helpers: byte-count/mask functions and the trim FSM state type.
package axi4_lib_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2
  } trim_state_t;

  // Number of valid bytes in a low-aligned tkeep: leftmost one + 1.
  function automatic logic [7:0] lmo_bytes(input logic [MAX_BYTES-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt = 8'(i + 1);
    end
    return cnt;
  endfunction

  function automatic logic [MAX_BYTES-1:0] low_mask(input logic [7:0] n);
    logic [MAX_BYTES-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle. Handshake: a beat moves on a rising edge where tvalid && tready; the master holds every field stable while tvalid && !tready.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/axi4_stream_byte_merge.sv
// Combinational repacker: appends the input's bytes (after dropping offset leading bytes) to the residue and splits off the overflow.
module axi4_stream_byte_merge
  import axi4_lib_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic [DATA_WIDTH-1:0]     res_data,
  input  logic [DATA_WIDTH_B-1:0]   res_strb,
  input  logic [DATA_WIDTH_B_W-1:0] res_cnt,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [DATA_WIDTH_B-1:0]   in_keep,
  input  logic [DATA_WIDTH_B-1:0]   in_strb,
  input  logic [DATA_WIDTH_B_W-1:0] offset,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [DATA_WIDTH_B-1:0]   out_keep,
  output logic [DATA_WIDTH_B-1:0]   out_strb,
  output logic                      full,
  output logic [DATA_WIDTH-1:0]     new_res_data,
  output logic [DATA_WIDTH_B-1:0]   new_res_strb,
  output logic [DATA_WIDTH_B_W-1:0] new_res_cnt
);

  localparam int CW = DATA_WIDTH_B_W + 2;

  logic [CW-1:0]           vb, off_w, n, tot, rem;
  logic [DATA_WIDTH-1:0]   sh_data, res_dmask;
  logic [DATA_WIDTH_B-1:0] sh_strb, res_keep;

  always_comb begin
    vb       = CW'(lmo_bytes(MAX_BYTES'(in_keep)));
    off_w    = CW'(offset);
    n        = (vb > off_w) ? vb - off_w : '0;
    tot      = CW'(res_cnt) + n;
    rem      = CW'(DATA_WIDTH_B) - CW'(res_cnt);
    sh_data  = in_data >> {offset, 3'b000};
    sh_strb  = in_strb >> offset;
    res_keep = DATA_WIDTH_B'(low_mask(8'(res_cnt)));
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      res_dmask[8*i +: 8] = {8{res_keep[i]}};
    end
    out_data = (res_data & res_dmask) | (sh_data << {res_cnt, 3'b000});
    out_keep = DATA_WIDTH_B'(low_mask(8'(tot)));
    out_strb = ((res_strb & res_keep) | (sh_strb << res_cnt)) & out_keep;
    full     = (tot >= CW'(DATA_WIDTH_B));
    // Overflow bytes start at shifted-input index W-res_cnt; a shift of a full word yields zero.
    if (full) begin
      new_res_data = sh_data >> {rem, 3'b000};
      new_res_strb = sh_strb >> rem;
      new_res_cnt  = DATA_WIDTH_B_W'(tot - CW'(DATA_WIDTH_B));
    end else begin
      new_res_data = out_data;
      new_res_strb = out_strb;
      new_res_cnt  = DATA_WIDTH_B_W'(tot);
    end
  end

endmodule

// File: rtl/axi4_stream_byte_trim.sv
// Drops trim_i leading bytes per packet and repacks the stream so every word but the last is full.
module axi4_stream_byte_trim
  import axi4_lib_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_B_W-1:0] trim_i,
  axi4_stream_if.slave              pkt_i,
  axi4_stream_if.master             pkt_o
);

  trim_state_t state, state_nxt;

  logic first, flush, out_free, in_ready, in_fire, flush_load;
  logic [DATA_WIDTH_B_W-1:0] offset;
  logic [DATA_WIDTH_B-1:0]   flush_keep;

  logic [DATA_WIDTH-1:0]     res_data;
  logic [DATA_WIDTH_B-1:0]   res_strb;
  logic [DATA_WIDTH_B_W-1:0] res_cnt;

  logic [DATA_WIDTH-1:0]     m_data, m_res_data;
  logic [DATA_WIDTH_B-1:0]   m_keep, m_strb, m_res_strb;
  logic [DATA_WIDTH_B_W-1:0] m_res_cnt;
  logic                      m_full;

  logic [ID_WIDTH-1:0]   id_q, sb_id, o_id;
  logic [DEST_WIDTH-1:0] dest_q, sb_dest, o_dest;
  logic [USER_WIDTH-1:0] user_q, sb_user, o_user;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [DATA_WIDTH_B-1:0] o_keep, o_strb;
  logic                    o_last, o_valid;

  axi4_stream_byte_merge #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DATA_WIDTH_B  (DATA_WIDTH_B),
    .DATA_WIDTH_B_W(DATA_WIDTH_B_W)
  ) u_merge (
    .res_data    (res_data),
    .res_strb    (res_strb),
    .res_cnt     (res_cnt),
    .in_data     (pkt_i.tdata),
    .in_keep     (pkt_i.tkeep),
    .in_strb     (pkt_i.tstrb),
    .offset      (offset),
    .out_data    (m_data),
    .out_keep    (m_keep),
    .out_strb    (m_strb),
    .full        (m_full),
    .new_res_data(m_res_data),
    .new_res_strb(m_res_strb),
    .new_res_cnt (m_res_cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_FIRST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FIRST, ST_BODY: begin
        if (in_fire) begin
          if (!pkt_i.tlast)                  state_nxt = ST_BODY;
          else if (m_full && m_res_cnt != '0) state_nxt = ST_FLUSH;
          else                               state_nxt = ST_FIRST;
        end
      end
      ST_FLUSH: if (out_free) state_nxt = ST_FIRST;
      default:  state_nxt = ST_FIRST;
    endcase
  end

  // The trim only matters on the first beat, so it is applied straight from trim_i as that beat is accepted.
  always_comb begin
    first      = (state == ST_FIRST);
    flush      = (state == ST_FLUSH);
    out_free   = !o_valid || pkt_o.tready;
    in_ready   = !flush && out_free;
    in_fire    = pkt_i.tvalid && in_ready;
    flush_load = flush && out_free;
    offset     = first ? trim_i : '0;
    flush_keep = DATA_WIDTH_B'(low_mask(8'(res_cnt)));
    sb_id      = first ? pkt_i.tid   : id_q;
    sb_dest    = first ? pkt_i.tdest : dest_q;
    sb_user    = first ? pkt_i.tuser : user_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_data <= '0;
      res_strb <= '0;
      res_cnt  <= '0;
      id_q     <= '0;
      dest_q   <= '0;
      user_q   <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_keep   <= '0;
      o_strb   <= '0;
      o_last   <= 1'b0;
      o_id     <= '0;
      o_dest   <= '0;
      o_user   <= '0;
    end else begin
      if (pkt_o.tready) o_valid <= 1'b0;
      if (in_fire && first) begin
        id_q   <= pkt_i.tid;
        dest_q <= pkt_i.tdest;
        user_q <= pkt_i.tuser;
      end
      if (flush_load) begin
        o_valid <= 1'b1;
        o_data  <= res_data;
        o_keep  <= flush_keep;
        o_strb  <= res_strb & flush_keep;
        o_last  <= 1'b1;
        o_id    <= id_q;
        o_dest  <= dest_q;
        o_user  <= user_q;
        res_cnt <= '0;
      end else if (in_fire) begin
        if (m_full || pkt_i.tlast) begin
          o_valid <= 1'b1;
          o_data  <= m_data;
          o_keep  <= m_keep;
          o_strb  <= m_strb;
          o_last  <= pkt_i.tlast && !(m_full && m_res_cnt != '0);
          o_id    <= sb_id;
          o_dest  <= sb_dest;
          o_user  <= sb_user;
        end
        res_data <= m_res_data;
        res_strb <= m_res_strb;
        res_cnt  <= (pkt_i.tlast && !m_full) ? '0 : m_res_cnt;
      end
    end
  end

  assign pkt_i.tready = in_ready;
  assign pkt_o.tvalid = o_valid;
  assign pkt_o.tdata  = o_data;
  assign pkt_o.tkeep  = o_keep;
  assign pkt_o.tstrb  = o_strb;
  assign pkt_o.tlast  = o_last;
  assign pkt_o.tid    = o_id;
  assign pkt_o.tdest  = o_dest;
  assign pkt_o.tuser  = o_user;

endmodule

// File: tb/tb_axi4_stream_byte_trim.sv
// Bench for axi4_stream_byte_trim: directed scenarios plus random packets against a byte-queue reference model.
module tb_axi4_stream_byte_trim;

  localparam int DW     = 32;
  localparam int W      = 4;
  localparam int BEAT_W = 44;  // {last, id, dest, user, keep[3:0], strb[3:0], data[31:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] trim = '0;

  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) out_if ();

  axi4_stream_byte_trim #(.DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .trim_i(trim),
    .pkt_i (in_if),
    .pkt_o (out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int rdy_low = 0;
  int stall_err = 0;
  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b1;

  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] got_q[$];
  int                in_cyc_q[$];
  int                out_cyc_q[$];
  logic [7:0]        pkt_bytes[$];
  logic              pkt_strb[$];
  int                pkt_fb;

  function automatic logic [BEAT_W-1:0] canon(input logic [BEAT_W-1:0] b);
    logic [BEAT_W-1:0] r;
    r = b;
    for (int j = 0; j < W; j++) begin
      if (!b[36+j]) begin
        r[8*j +: 8] = 8'h00;
        r[32+j]     = 1'b0;
      end
    end
    return r;
  endfunction

  // ---------------- clock/reset-side processes ----------------
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: records transfers, input-stall cycles and output stability while stalled.
  initial begin
    logic              held;
    logic [BEAT_W-1:0] held_beat, cur;
    held = 1'b0;
    held_beat = '0;
    forever begin
      @(negedge clk);
      cur = {out_if.tlast, out_if.tid, out_if.tdest, out_if.tuser, out_if.tkeep, out_if.tstrb, out_if.tdata};
      if (rst) begin
        held = 1'b0;
      end else begin
        if (in_if.tvalid && in_if.tready) in_cyc_q.push_back(cycle);
        if (!in_if.tready) rdy_low++;
        if (held && !(out_if.tvalid && cur == held_beat)) stall_err++;
        if (out_if.tvalid && out_if.tready) begin
          got_q.push_back(cur);
          out_cyc_q.push_back(cycle);
          held = 1'b0;
        end else begin
          held      = out_if.tvalid;
          held_beat = cur;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_q();
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    in_cyc_q.delete();
    out_cyc_q.delete();
    rdy_low = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                           input logic l, input logic id, input logic dest, input logic user,
                           input logic [1:0] tr);
    bit ok;
    ok = 1'b0;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tstrb  = s;
    in_if.tlast  = l;
    in_if.tid    = id;
    in_if.tdest  = dest;
    in_if.tuser  = user;
    trim         = tr;
    in_if.tvalid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      ok = in_if.tready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_if.tvalid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: tready=%b required 1 within 200 cycles", in_if.tready);
    end
  endtask

  task automatic make_pkt(input int len, input int fb, input bit rnd);
    pkt_bytes.delete();
    pkt_strb.delete();
    pkt_fb = fb;
    for (int k = 0; k < len; k++) begin
      pkt_bytes.push_back(rnd ? 8'($urandom) : 8'(8'hA0 + k));
      pkt_strb.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  endtask

  // Reference: the trimmed byte stream chunked into W-byte words; an empty result is one keep=0 beat.
  task automatic send_pkt(input int tr, input logic id, input logic dest, input logic user);
    int len, drop, rem, nb, cnt, pos, k;
    logic [31:0] d;
    logic [3:0]  kp, s;
    len  = pkt_bytes.size();
    drop = (tr < pkt_fb) ? tr : pkt_fb;
    rem  = len - drop;
    nb   = (rem == 0) ? 1 : (rem + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      cnt = rem - b * W;
      if (cnt > W) cnt = W;
      d = '0; kp = '0; s = '0;
      for (int j = 0; j < cnt; j++) begin
        d[8*j +: 8] = pkt_bytes[drop + b*W + j];
        kp[j]       = 1'b1;
        s[j]        = pkt_strb[drop + b*W + j];
      end
      exp_q.push_back({(b == nb - 1), id, dest, user, kp, s, d});
    end
    pos = 0;
    while (pos < len) begin
      k = (pos == 0) ? pkt_fb : ((len - pos > W) ? W : len - pos);
      d = $urandom; kp = '0; s = '0;
      for (int j = 0; j < k; j++) begin
        d[8*j +: 8] = pkt_bytes[pos + j];
        kp[j]       = 1'b1;
        s[j]        = pkt_strb[pos + j];
      end
      send_beat(d, kp, s, (pos + k == len), id, dest, user,
                (pos == 0) ? 2'(tr) : 2'($urandom_range(0, 3)));
      pos += k;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    for (int c = 0; c < budget && got_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (4) @(negedge clk);
    ok = (got_q.size() == exp_q.size());
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++; if (out_if.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", out_if.tvalid); end
    checks++; if (out_if.tkeep !== 4'h0) begin failures++; $display("FAIL reset_tkeep: got %h want 0", out_if.tkeep); end
    checks++; if (out_if.tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h want 0", out_if.tdata); end
    checks++; if (out_if.tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", out_if.tlast); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_if.tready !== 1'b1) begin failures++; $display("FAIL reset_tready: got %b want 1", in_if.tready); end
  endtask

  task automatic test_passthrough();
    bit ok;
    clear_q();
    make_pkt(10, 4, 1'b0);
    send_pkt(0, 1'b1, 1'b0, 1'b1);
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pass_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (canon(got_q[i]) !== canon(exp_q[i])) begin failures++; $display("FAIL pass_beat%0d: got %h want %h", i, canon(got_q[i]), canon(exp_q[i])); end
    end
    checks++; if (got_q.size() < 3 || got_q[2][39:36] !== 4'b0011) begin failures++; $display("FAIL pass_last_keep: got %h want 3", got_q[2][39:36]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_cyc_q.size() < 3 || out_cyc_q.size() < 3 || out_cyc_q[i] !== in_cyc_q[i] + 1) begin
        failures++; $display("FAIL pass_latency%0d: out cycle %0d want %0d", i, out_cyc_q[i], in_cyc_q[i] + 1);
      end
    end
  endtask

  task automatic test_trim_one();
    bit ok;
    clear_q();
    make_pkt(12, 4, 1'b0);
    send_pkt(1, 1'b0, 1'b1, 1'b0);
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trim1_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (canon(got_q[i]) !== canon(exp_q[i])) begin failures++; $display("FAIL trim1_beat%0d: got %h want %h", i, canon(got_q[i]), canon(exp_q[i])); end
    end
    checks++; if (got_q[0][31:0] !== 32'hA4A3A2A1 || got_q[0][43] !== 1'b0) begin failures++; $display("FAIL trim1_first: got %h want A4A3A2A1 last 0", got_q[0]); end
    checks++; if (got_q[2][39:36] !== 4'b0111 || got_q[2][43] !== 1'b1) begin failures++; $display("FAIL trim1_tail: got %h want keep 7 last 1", got_q[2]); end
  endtask

  task automatic test_flush();
    bit ok;
    clear_q();
    make_pkt(10, 2, 1'b0);
    send_pkt(0, 1'b1, 1'b1, 1'b1);
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL flush_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (canon(got_q[i]) !== canon(exp_q[i])) begin failures++; $display("FAIL flush_beat%0d: got %h want %h", i, canon(got_q[i]), canon(exp_q[i])); end
    end
    checks++; if (got_q[0][31:0] !== 32'hA3A2A1A0) begin failures++; $display("FAIL flush_first: got %h want A3A2A1A0", got_q[0][31:0]); end
    checks++; if (got_q[2][39:36] !== 4'b0011 || got_q[2][43] !== 1'b1) begin failures++; $display("FAIL flush_tail: got %h want keep 3 last 1", got_q[2]); end
    checks++; if (rdy_low !== 1) begin failures++; $display("FAIL flush_ready_low: got %0d cycles want 1", rdy_low); end
  endtask

  task automatic test_single_trim();
    bit ok;
    clear_q();
    make_pkt(4, 4, 1'b0);
    send_pkt(3, 1'b0, 1'b0, 1'b1);
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_count: got %0d beats want 1", got_q.size()); end
    checks++;
    if (got_q[0][7:0] !== 8'hA3 || got_q[0][39:36] !== 4'b0001 || got_q[0][43] !== 1'b1) begin
      failures++; $display("FAIL single_beat: got %h want byte A3 keep 1 last 1", got_q[0]);
    end
  endtask

  task automatic test_empty_back_to_back();
    bit ok;
    clear_q();
    make_pkt(2, 2, 1'b0);
    send_pkt(2, 1'b1, 1'b0, 1'b0);
    make_pkt(6, 4, 1'b1);
    send_pkt(0, 1'b0, 1'b1, 1'b1);
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q[0][39:36] !== 4'b0000 || got_q[0][43] !== 1'b1) begin failures++; $display("FAIL empty_beat: got %h want keep 0 last 1", got_q[0]); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (canon(got_q[i]) !== canon(exp_q[i])) begin failures++; $display("FAIL b2b_beat%0d: got %h want %h", i, canon(got_q[i]), canon(exp_q[i])); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int nbeats, fb, len;
    clear_q();
    rdy_rand  = 1'b1;
    stall_err = 0;
    for (int p = 0; p < 200; p++) begin
      nbeats = $urandom_range(1, 5);
      fb     = $urandom_range(1, W);
      len    = (nbeats == 1) ? fb : fb + W * (nbeats - 2) + int'($urandom_range(1, W));
      make_pkt(len, fb, 1'b1);
      send_pkt($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_drain(8000, ok);
    rdy_rand = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL rand_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (canon(got_q[i]) !== canon(exp_q[i])) begin failures++; $display("FAIL rand_beat%0d: got %h want %h", i, canon(got_q[i]), canon(exp_q[i])); end
    end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL rand_stall_stable: got %0d changes want 0", stall_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send_beat(32'h11223344, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    @(negedge clk);
    checks++; if (out_if.tvalid !== 1'b1) begin failures++; $display("FAIL midrst_loaded: got tvalid %b want 1", out_if.tvalid); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_if.tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tvalid: got %b want 0", out_if.tvalid); end
    checks++; if (out_if.tkeep !== 4'h0 || out_if.tdata !== 32'h0 || out_if.tlast !== 1'b0) begin
      failures++; $display("FAIL midrst_fields: got keep %h data %h last %b want 0", out_if.tkeep, out_if.tdata, out_if.tlast);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_force = 1'b1;
    clear_q();
    make_pkt(7, 3, 1'b1);
    send_pkt(2, 1'b0, 1'b1, 1'b0);
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (canon(got_q[i]) !== canon(exp_q[i])) begin failures++; $display("FAIL midrst_beat%0d: got %h want %h", i, canon(got_q[i]), canon(exp_q[i])); end
    end
  endtask

  initial begin
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tstrb   = '0;
    in_if.tlast   = 1'b0;
    in_if.tid     = '0;
    in_if.tdest   = '0;
    in_if.tuser   = '0;
    out_if.tready = 1'b1;
    test_reset();
    test_passthrough();
    test_trim_one();
    test_flush();
    test_single_trim();
    test_empty_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
